data_cache: RTL

- Direct-mapped, write-back, write-allocate data cache.
- Sits between the CPU load/store path and the byte-wide `data_mem` block.
- Read and write hits complete without stalling the CPU.
- Misses stall the CPU through `cpu_busy_wait` while whole blocks are moved byte by byte over the memory handshake.

---
 rtl/cache_pkg.sv | 33 +++
 rtl/cache_line_store.sv | 71 +++++++
 rtl/data_cache.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared types and geometry for the data cache.
//   - cache_state_e : controller states
//   - DEF_LINES / DEF_BLOCK_BYTES : default geometry
//   - INDEX_W / OFFSET_W / TAG_W : address split for the default geometry
//   - addr_field()  : extracts a bit field from a byte address
package cache_pkg;

  localparam int unsigned ADDR_W          = 8;
  localparam int unsigned DATA_W          = 8;
  localparam int unsigned DEF_LINES       = 8;
  localparam int unsigned DEF_BLOCK_BYTES = 4;

  localparam int unsigned INDEX_W  = $clog2(DEF_LINES);
  localparam int unsigned OFFSET_W = $clog2(DEF_BLOCK_BYTES);
  localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } cache_state_e;

  // Returns addr[lsb +: width], zero-extended to the address width.
  function automatic logic [ADDR_W-1:0] addr_field(input logic [ADDR_W-1:0] addr,
                                                   input int unsigned       lsb,
                                                   input int unsigned       width);
    logic [ADDR_W-1:0] mask;
    mask = ADDR_W'((1 << width) - 1);
    return (addr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// cache_line_store: tag/valid/dirty/data arrays of the direct-mapped cache.
//   lookup_*  : combinational read of the line selected by lookup_index
//   blk_*     : synchronous whole-block fill (sets valid, clears dirty)
//   byte_*    : synchronous single-byte store (sets dirty)
//   rst       : synchronous active-high, clears valid and dirty only
module cache_line_store
  import cache_pkg::*;
#(
  parameter int unsigned LINES       = DEF_LINES,
  parameter int unsigned BLOCK_BYTES = DEF_BLOCK_BYTES,
  parameter int unsigned IDX_W       = $clog2(LINES),
  parameter int unsigned OFF_W       = $clog2(BLOCK_BYTES),
  parameter int unsigned TG_W        = ADDR_W - IDX_W - OFF_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [IDX_W-1:0]                    lookup_index,
  output logic [TG_W-1:0]                     lookup_tag,
  output logic                                lookup_valid,
  output logic                                lookup_dirty,
  output logic [BLOCK_BYTES-1:0][DATA_W-1:0]  lookup_block,
  input  logic                                blk_we,
  input  logic [IDX_W-1:0]                    blk_index,
  input  logic [TG_W-1:0]                     blk_tag,
  input  logic [BLOCK_BYTES-1:0][DATA_W-1:0]  blk_data,
  input  logic                                byte_we,
  input  logic [IDX_W-1:0]                    byte_index,
  input  logic [OFF_W-1:0]                    byte_offset,
  input  logic [DATA_W-1:0]                   byte_data
);

  typedef logic [BLOCK_BYTES-1:0][DATA_W-1:0] block_t;

  logic [TG_W-1:0]  tags  [LINES];
  block_t           data  [LINES];
  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;

  // Line status bits: the only state that needs reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (blk_we) begin
        valid[blk_index] <= 1'b1;
        dirty[blk_index] <= 1'b0;
      end
      if (byte_we) begin
        dirty[byte_index] <= 1'b1;
      end
    end
  end

  // Tag and data storage.
  always_ff @(posedge clk) begin
    if (blk_we) begin
      tags[blk_index] <= blk_tag;
      data[blk_index] <= blk_data;
    end
    if (byte_we) begin
      data[byte_index][byte_offset] <= byte_data;
    end
  end

  assign lookup_tag   = tags[lookup_index];
  assign lookup_valid = valid[lookup_index];
  assign lookup_dirty = dirty[lookup_index];
  assign lookup_block = data[lookup_index];

endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache.
//   CPU side : cpu_read/cpu_write/cpu_address/cpu_write_data in,
//              cpu_read_data/cpu_busy_wait out (both combinational)
//   Mem side : mem_read/mem_write/mem_address/mem_write_data out (decoded
//              from state and byte counter), mem_read_data/mem_busy_wait in
//   clk, rst : single clock, synchronous active-high reset
// Hits complete with no stall; misses move whole blocks byte by byte.
module data_cache
  import cache_pkg::*;
#(
  parameter int unsigned LINES       = DEF_LINES,
  parameter int unsigned BLOCK_BYTES = DEF_BLOCK_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_write_data,
  output logic [DATA_W-1:0] cpu_read_data,
  output logic              cpu_busy_wait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_busy_wait
);

  localparam int unsigned LINE_IDX_W = $clog2(LINES);
  localparam int unsigned BYTE_OFF_W = $clog2(BLOCK_BYTES);
  localparam int unsigned LINE_TAG_W = ADDR_W - LINE_IDX_W - BYTE_OFF_W;
  localparam logic [BYTE_OFF_W-1:0] LAST_BYTE = BYTE_OFF_W'(BLOCK_BYTES - 1);

  cache_state_e state, next_state;
  logic [BYTE_OFF_W-1:0] cnt, next_cnt;
  logic [BLOCK_BYTES-1:0][DATA_W-1:0] fill_buf;

  logic [LINE_TAG_W-1:0] addr_tag;
  logic [LINE_IDX_W-1:0] addr_idx;
  logic [BYTE_OFF_W-1:0] addr_off;

  logic [LINE_TAG_W-1:0]              line_tag;
  logic                               line_valid;
  logic                               line_dirty;
  logic [BLOCK_BYTES-1:0][DATA_W-1:0] line_block;

  logic req_rd, req_wr, hit;
  logic blk_we, byte_we, fill_we;

  assign addr_off = BYTE_OFF_W'(addr_field(cpu_address, 0, BYTE_OFF_W));
  assign addr_idx = LINE_IDX_W'(addr_field(cpu_address, BYTE_OFF_W, LINE_IDX_W));
  assign addr_tag = LINE_TAG_W'(addr_field(cpu_address, BYTE_OFF_W + LINE_IDX_W, LINE_TAG_W));

  // Both request lines high is treated as no request.
  assign req_rd = cpu_read & ~cpu_write;
  assign req_wr = cpu_write & ~cpu_read;
  assign hit    = line_valid && (line_tag == addr_tag);

  cache_line_store #(
    .LINES       (LINES),
    .BLOCK_BYTES (BLOCK_BYTES),
    .IDX_W       (LINE_IDX_W),
    .OFF_W       (BYTE_OFF_W),
    .TG_W        (LINE_TAG_W)
  ) u_store (
    .clk          (clk),
    .rst          (rst),
    .lookup_index (addr_idx),
    .lookup_tag   (line_tag),
    .lookup_valid (line_valid),
    .lookup_dirty (line_dirty),
    .lookup_block (line_block),
    .blk_we       (blk_we),
    .blk_index    (addr_idx),
    .blk_tag      (addr_tag),
    .blk_data     (fill_buf),
    .byte_we      (byte_we),
    .byte_index   (addr_idx),
    .byte_offset  (addr_off),
    .byte_data    (cpu_write_data)
  );

  // State and byte counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Fill buffer collects fetched bytes until UPDATE commits them.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      fill_buf[cnt] <= mem_read_data;
    end
  end

  // Next state, counter and output decode.
  always_comb begin
    next_state     = state;
    next_cnt       = cnt;
    cpu_busy_wait  = 1'b0;
    cpu_read_data  = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    blk_we         = 1'b0;
    byte_we        = 1'b0;
    fill_we        = 1'b0;

    unique case (state)
      IDLE: begin
        if (req_rd || req_wr) begin
          if (hit) begin
            if (req_rd) begin
              cpu_read_data = line_block[addr_off];
            end else begin
              byte_we = 1'b1;
            end
          end else begin
            cpu_busy_wait = 1'b1;
            next_cnt      = '0;
            next_state    = (line_valid && line_dirty) ? WRITEBACK : FETCH;
          end
        end
      end

      WRITEBACK: begin
        cpu_busy_wait  = 1'b1;
        mem_write      = 1'b1;
        mem_address    = {line_tag, addr_idx, cnt};
        mem_write_data = line_block[cnt];
        if (!mem_busy_wait) begin
          if (cnt == LAST_BYTE) begin
            next_cnt   = '0;
            next_state = FETCH;
          end else begin
            next_cnt = cnt + 1'b1;
          end
        end
      end

      FETCH: begin
        cpu_busy_wait = 1'b1;
        mem_read      = 1'b1;
        mem_address   = {addr_tag, addr_idx, cnt};
        if (!mem_busy_wait) begin
          fill_we = 1'b1;
          if (cnt == LAST_BYTE) begin
            next_cnt   = '0;
            next_state = UPDATE;
          end else begin
            next_cnt = cnt + 1'b1;
          end
        end
      end

      UPDATE: begin
        cpu_busy_wait = 1'b1;
        blk_we        = 1'b1;
        next_state    = IDLE;
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule
